// File: rtl/chunk_responder.sv
// Responder side of the cipher core's chunk interface: holds the host-loaded key, nonce
// and block-counter bank and answers each chunk request after a programmable delay.
module chunk_responder #(
    parameter int unsigned RESP_DELAY = 2,
    parameter logic [31:0] CTR_RESET  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_type,
    input  logic [4:0]  cfg_index,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_err,
    input  logic        ctr_inc,
    output logic        ctr_wrap,
    input  logic        chunk_request,
    input  logic [1:0]  request_type,
    input  logic [4:0]  chunk_index,
    output logic [31:0] chunk,
    output logic [1:0]  chunk_type,
    output logic        chunk_valid,
    output logic        req_error,
    output logic        req_overrun,
    output logic        busy,
    input  logic        clr_flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] T_KEY   = 2'd0;
    localparam logic [1:0] T_NONCE = 2'd1;
    localparam logic [1:0] T_CTR   = 2'd2;

    function automatic logic idx_ok(input logic [1:0] t, input logic [4:0] i);
        case (t)
            T_KEY:   return i < 5'd8;
            T_NONCE: return i < 5'd3;
            T_CTR:   return i == 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    logic [31:0] key_q [8];
    logic [31:0] nonce_q [3];
    logic [31:0] ctr_q;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic [31:0] snap_q;
    logic [1:0]  type_q;
    logic        err_q;

    logic        wr_ok, ctr_write, wrap_evt;
    logic        rd_ok;
    logic [31:0] rd_word;

    assign wr_ok     = idx_ok(cfg_type, cfg_index);
    assign ctr_write = cfg_we && wr_ok && (cfg_type == T_CTR);
    // A counter write in the same cycle swallows the increment, so it cannot wrap.
    assign wrap_evt  = ctr_inc && !ctr_write && (ctr_q == 32'hFFFF_FFFF);
    assign busy      = (state_q != S_IDLE);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        rd_word = '0;
        rd_ok   = idx_ok(request_type, chunk_index);
        if (rd_ok) begin
            case (request_type)
                T_KEY:   rd_word = key_q[chunk_index[2:0]];
                T_NONCE: rd_word = nonce_q[chunk_index[1:0]];
                T_CTR:   rd_word = ctr_q;
                default: rd_word = '0;
            endcase
        end
    end

    // NOTE: the key/nonce bank is reset explicitly because a cleared bank is part of the
    // block's visible reset state; that rules out mapping it onto reset-less RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) key_q[i] <= '0;
            for (int i = 0; i < 3; i++) nonce_q[i] <= '0;
            ctr_q       <= CTR_RESET;
            cfg_err     <= 1'b0;
            ctr_wrap    <= 1'b0;
            req_overrun <= 1'b0;
        end else begin
            if (cfg_we && wr_ok) begin
                case (cfg_type)
                    T_KEY:   key_q[cfg_index[2:0]]   <= cfg_wdata;
                    T_NONCE: nonce_q[cfg_index[1:0]] <= cfg_wdata;
                    default: ;
                endcase
            end
            if (ctr_write)    ctr_q <= cfg_wdata;
            else if (ctr_inc) ctr_q <= ctr_q + 32'd1;

            // Set events take priority over clr_flags.
            cfg_err     <= (cfg_we && !wr_ok)      || (cfg_err     && !clr_flags);
            ctr_wrap    <= wrap_evt                || (ctr_wrap    && !clr_flags);
            req_overrun <= (chunk_request && busy) || (req_overrun && !clr_flags);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (chunk_request) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(RESP_DELAY - 1);
                    state_d = (RESP_DELAY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; this is also what hides a same-cycle write from the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            snap_q      <= '0;
            type_q      <= '0;
            err_q       <= 1'b0;
            chunk       <= '0;
            chunk_type  <= '0;
            chunk_valid <= 1'b0;
            req_error   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                snap_q <= rd_word;
                type_q <= request_type;
                err_q  <= !rd_ok;
            end
            chunk_valid <= (state_q == S_RESP);
            req_error   <= (state_q == S_RESP) && err_q;
            if (state_q == S_RESP) begin
                chunk      <= snap_q;
                chunk_type <= type_q;
            end
        end
    end

endmodule

// File: doc/chunk_responder.md
Name: chunk_responder

Overview:
- Responder end of the chunk request interface used by the cipher core.
- Holds a host-loaded bank of key (8 words), nonce (3 words) and block counter (1 word).
- Answers each `chunk_request` / `request_type` / `chunk_index` with one `chunk` / `chunk_type` / `chunk_valid` beat after a programmable delay.
- Sits between the host config port and the cipher core's chunk interface; also owns block-counter increment.

Parameters:
- RESP_DELAY, 2, cycles from request acceptance edge to `chunk_valid`; legal range 1..15.
- CTR_RESET, 0, reset and clear value of counter word 0.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cfg_we  input  1  host bank write strobe
- cfg_type  input  2  bank select: 0 key, 1 nonce, 2 counter, 3 reserved
- cfg_index  input  5  word index within bank
- cfg_wdata  input  32  write data
- cfg_err  output  1  sticky: write to reserved type or out-of-range index
- ctr_inc  input  1  pulse: counter word += 1
- ctr_wrap  output  1  sticky: counter wrapped 0xFFFFFFFF->0
- chunk_request  input  1  request strobe from core
- request_type  input  2  requested bank
- chunk_index  input  5  requested word
- chunk  output  32  response data
- chunk_type  output  2  echo of accepted request_type
- chunk_valid  output  1  one-cycle response strobe
- req_error  output  1  one-cycle pulse with chunk_valid for bad type/index
- req_overrun  output  1  sticky: request dropped while busy
- busy  output  1  high outside IDLE
- clr_flags  input  1  clears cfg_err, ctr_wrap, req_overrun

Behaviour:
- Reset, synchronous, rst=1 at posedge:
  - state IDLE.
  - chunk=0, chunk_type=0, chunk_valid=0, req_error=0, busy=0.
  - All sticky flags 0.
  - Key and nonce words 0; counter = CTR_RESET.
  - Reset mid-operation aborts any pending response; no chunk_valid is issued for it.
- Bank limits: key index 0..7, nonce 0..2, counter 0 only. Anything else is invalid.
- Config write:
  - cfg_we=1 with valid type/index updates the word at the edge.
  - Invalid type/index: no storage change, cfg_err<=1.
- Counter update:
  - ctr_inc=1 adds 1 mod 2^32. From 0xFFFFFFFF it yields 0 and sets ctr_wrap<=1.
  - cfg_we to counter in the same cycle as ctr_inc: the write wins and the increment is lost.
- Flag clearing: clr_flags=1 clears all sticky flags. A set event in the same cycle wins (flag ends 1).
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - chunk_request=1 -> accept.
    - Latch type and index; snapshot the addressed word (0 if invalid) plus the invalid bit.
    - Snapshot uses pre-edge storage, so a same-cycle cfg write or ctr_inc is not visible.
    - Load delay counter with RESP_DELAY-1.
    - Go to WAIT, or to RESP if RESP_DELAY=1.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP:
    - chunk_valid=1, chunk=snapshot, chunk_type=latched type, req_error=invalid bit, all for exactly one cycle.
    - Next state IDLE.
    - chunk holds its value afterwards; chunk_valid and req_error return to 0.
- Latency: request sampled at edge E0 -> chunk_valid high in the cycle after edge E(RESP_DELAY).
- Throughput: a new request is accepted at the earliest one cycle after chunk_valid.
- busy=1 in WAIT and RESP.
- Requests while busy: chunk_request=1 in WAIT/RESP is dropped with no response, and req_overrun<=1.
- No backpressure: the core must accept chunk_valid when it occurs.

Test Plan:
- Reset, then key load and read:
  - Load key[0..7]=0x00010203..; request type0 idx5 (RESP_DELAY=2).
  - Expect chunk_valid exactly 2 cycles after acceptance, chunk=key[5], chunk_type=0, req_error=0, busy high 2 cycles.
- Invalid requests:
  - Request type1 idx3 -> chunk=0, req_error=1 with chunk_valid.
  - Request type3 idx0 -> same response.
  - cfg_we type2 idx1 -> cfg_err=1, counter unchanged.
- Counter wrap and flag clear:
  - cfg write counter=0xFFFFFFFF, then ctr_inc pulse -> request type2 idx0 returns 0x00000000, ctr_wrap=1.
  - clr_flags -> ctr_wrap=0.
- Same-cycle collisions:
  - ctr_inc and cfg_we counter=0x10 in one cycle -> read returns 0x10.
  - Request nonce0 in the same cycle as cfg write nonce0=0xAA -> returns old value; next request returns 0xAA.
- Overrun: second chunk_request while busy -> exactly one chunk_valid, req_overrun=1, stored data intact.
- Reset during WAIT: rst=1 at WAIT -> no chunk_valid afterwards, busy=0, key words read back 0 after reset.
